// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencing controller: operand forwarding, load-use bubbles,
// redirect squash, memory-busy freeze and post-HALT parking.
module ex_hazard_ctrl #(
  parameter int unsigned LOADUSE_STALL = 1,
  parameter int unsigned REG_BITS      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] ifid_rs,
  input  logic [REG_BITS-1:0] ifid_rt,
  input  logic                ifid_useRs,
  input  logic                ifid_useRt,
  input  logic [REG_BITS-1:0] idex_rs,
  input  logic [REG_BITS-1:0] idex_rt,
  input  logic                idex_useRs,
  input  logic                idex_useRt,
  input  logic [REG_BITS-1:0] idex_rd,
  input  logic                idex_regWrite,
  input  logic                idex_memRead,
  input  logic [REG_BITS-1:0] exmem_rd,
  input  logic                exmem_regWrite,
  input  logic                exmem_memRead,
  input  logic [REG_BITS-1:0] memwb_rd,
  input  logic                memwb_regWrite,
  input  logic                redirect,
  input  logic                halt_ex,
  input  logic                mem_stall,
  output logic [1:0]          forwardA,
  output logic [1:0]          forwardB,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                idex_bubble,
  output logic                ifid_flush,
  output logic                pipe_freeze,
  output logic                halted
);

  typedef enum logic [1:0] {StRun, StStall, StHalted} state_e;

  // Counter holds the bubbles still owed after the first one (issued from RUN).
  localparam logic [1:0] StallReload = 2'(LOADUSE_STALL - 1);
  localparam bit         MultiStall  = (LOADUSE_STALL > 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       load_use;

  // Forwarding: EX/MEM wins over MEM/WB; a load in EX/MEM has no ALU result.
  always_comb begin
    forwardA = 2'b00;
    if (exmem_regWrite && !exmem_memRead && idex_useRs && (exmem_rd == idex_rs)) begin
      forwardA = 2'b10;
    end else if (memwb_regWrite && idex_useRs && (memwb_rd == idex_rs)) begin
      forwardA = 2'b01;
    end
  end

  always_comb begin
    forwardB = 2'b00;
    if (exmem_regWrite && !exmem_memRead && idex_useRt && (exmem_rd == idex_rt)) begin
      forwardB = 2'b10;
    end else if (memwb_regWrite && idex_useRt && (memwb_rd == idex_rt)) begin
      forwardB = 2'b01;
    end
  end

  always_comb begin
    load_use = idex_memRead && idex_regWrite &&
               ((ifid_useRs && (idex_rd == ifid_rs)) ||
                (ifid_useRt && (idex_rd == ifid_rt)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A frozen pipeline re-presents redirect/halt_ex later, so they are ignored here.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_stall) begin
      unique case (state_q)
        StRun, StStall: begin
          if (redirect) begin
            state_d = StRun;
            cnt_d   = 2'd0;
          end else if (halt_ex) begin
            state_d = StHalted;
            cnt_d   = 2'd0;
          end else if (state_q == StStall) begin
            if (cnt_q <= 2'd1) begin
              state_d = StRun;
              cnt_d   = 2'd0;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end else if (load_use && MultiStall) begin
            state_d = StStall;
            cnt_d   = StallReload;
          end
        end
        StHalted: begin
          state_d = StHalted;
        end
        default: begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    halted      = (state_q == StHalted);
    if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else begin
      unique case (state_q)
        StRun, StStall: begin
          if (redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (halt_ex || load_use || (state_q == StStall)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        StHalted: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
        default: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: two instances (LOADUSE_STALL=1 and 3)
// share stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b1;
  logic       rst;
  logic [2:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic       ifid_useRs, ifid_useRt, idex_useRs, idex_useRt;
  logic       idex_regWrite, idex_memRead, exmem_regWrite, exmem_memRead, memwb_regWrite;
  logic       redirect, halt_ex, mem_stall;

  logic [1:0] fa1, fb1, fa3, fb3;
  logic       pcw1, ifw1, bub1, fl1, frz1, hlt1;
  logic       pcw3, ifw3, bub3, fl3, frz3, hlt3;

  // Control vector order: {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze, halted}
  localparam logic [5:0] CRun    = 6'b110000;
  localparam logic [5:0] CBub    = 6'b001000;
  localparam logic [5:0] CRedir  = 6'b111100;
  localparam logic [5:0] CFrz    = 6'b000010;
  localparam logic [5:0] CHlt    = 6'b001001;
  localparam logic [5:0] CHltFrz = 6'b000011;

  typedef struct {
    string      name;
    logic [3:0] fwd;
    logic [5:0] c1;
    logic [5:0] c3;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.LOADUSE_STALL(1), .REG_BITS(3)) dut1 (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_useRs(ifid_useRs), .ifid_useRt(ifid_useRt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_useRs(idex_useRs), .idex_useRt(idex_useRt),
    .idex_rd(idex_rd), .idex_regWrite(idex_regWrite), .idex_memRead(idex_memRead),
    .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite), .exmem_memRead(exmem_memRead),
    .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite),
    .redirect(redirect), .halt_ex(halt_ex), .mem_stall(mem_stall),
    .forwardA(fa1), .forwardB(fb1), .pc_write(pcw1), .ifid_write(ifw1),
    .idex_bubble(bub1), .ifid_flush(fl1), .pipe_freeze(frz1), .halted(hlt1)
  );

  ex_hazard_ctrl #(.LOADUSE_STALL(3), .REG_BITS(3)) dut3 (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_useRs(ifid_useRs), .ifid_useRt(ifid_useRt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_useRs(idex_useRs), .idex_useRt(idex_useRt),
    .idex_rd(idex_rd), .idex_regWrite(idex_regWrite), .idex_memRead(idex_memRead),
    .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite), .exmem_memRead(exmem_memRead),
    .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite),
    .redirect(redirect), .halt_ex(halt_ex), .mem_stall(mem_stall),
    .forwardA(fa3), .forwardB(fb3), .pc_write(pcw3), .ifid_write(ifw3),
    .idex_bubble(bub3), .ifid_flush(fl3), .pipe_freeze(frz3), .halted(hlt3)
  );

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, "/fwd1"}, {2'b00, fa1, fb1}, {2'b00, e.fwd});
      chk({e.name, "/fwd3"}, {2'b00, fa3, fb3}, {2'b00, e.fwd});
      chk({e.name, "/ctl1"}, {pcw1, ifw1, bub1, fl1, frz1, hlt1}, e.c1);
      chk({e.name, "/ctl3"}, {pcw3, ifw3, bub3, fl3, frz3, hlt3}, e.c3);
    end
  end

  task automatic step(input string nm, input logic [3:0] fwd, input logic [5:0] c1,
                      input logic [5:0] c3);
    exp_t x;
    x.name = nm;
    x.fwd  = fwd;
    x.c1   = c1;
    x.c3   = c3;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd} = '0;
    {ifid_useRs, ifid_useRt, idex_useRs, idex_useRt} = '0;
    {idex_regWrite, idex_memRead, exmem_regWrite, exmem_memRead, memwb_regWrite} = '0;
    {redirect, halt_ex, mem_stall} = '0;
  endtask

  task automatic set_load_use_rt();
    idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_rd = 3'd2;
    ifid_rt = 3'd2; ifid_useRt = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step("reset0", 4'b0000, CRun, CRun);
    step("reset1", 4'b0000, CRun, CRun);
    rst = 1'b0;

    // Forwarding
    idex_rs = 3'd3; idex_useRs = 1'b1;
    exmem_rd = 3'd3; exmem_regWrite = 1'b1; memwb_rd = 3'd3; memwb_regWrite = 1'b1;
    step("fwd_exmem", 4'b1000, CRun, CRun);
    exmem_regWrite = 1'b0;
    step("fwd_memwb", 4'b0100, CRun, CRun);
    exmem_regWrite = 1'b1; exmem_memRead = 1'b1;
    step("fwd_load_in_mem", 4'b0100, CRun, CRun);
    exmem_memRead = 1'b0; idex_rs = 3'd4; idex_rt = 3'd3; idex_useRt = 1'b1;
    step("fwd_b_exmem", 4'b0010, CRun, CRun);
    idex_rs = 3'd0; idex_rt = 3'd0; exmem_rd = 3'd7; memwb_rd = 3'd0;
    step("fwd_r0", 4'b0101, CRun, CRun);
    idex_useRs = 1'b0;
    step("fwd_no_use", 4'b0001, CRun, CRun);
    idle();

    // Load-use via rt: one bubble for dut1, three for dut3
    set_load_use_rt();
    step("lu_b1", 4'b0000, CBub, CBub);
    idle();
    step("lu_b2", 4'b0000, CRun, CBub);
    step("lu_b3", 4'b0000, CRun, CBub);
    step("lu_done", 4'b0000, CRun, CRun);
    set_load_use_rt(); ifid_useRt = 1'b0;
    step("lu_no_use", 4'b0000, CRun, CRun);
    ifid_useRt = 1'b1; idex_regWrite = 1'b0;
    step("lu_no_wr", 4'b0000, CRun, CRun);
    idle();

    // Redirect during the second stall cycle (hazard via rs)
    idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_rd = 3'd5;
    ifid_rs = 3'd5; ifid_useRs = 1'b1;
    step("rd_stall", 4'b0000, CBub, CBub);
    idle(); redirect = 1'b1;
    step("rd_flush", 4'b0000, CRedir, CRedir);
    redirect = 1'b0;
    step("rd_after", 4'b0000, CRun, CRun);
    step("rd_after2", 4'b0000, CRun, CRun);

    // mem_stall held for 4 cycles inside a 3-cycle stall
    set_load_use_rt();
    step("ms_b1", 4'b0000, CBub, CBub);
    idle(); mem_stall = 1'b1;
    step("ms_frz1", 4'b0000, CFrz, CFrz);
    redirect = 1'b1; halt_ex = 1'b1;
    step("ms_frz2_ignore", 4'b0000, CFrz, CFrz);
    redirect = 1'b0; halt_ex = 1'b0;
    step("ms_frz3", 4'b0000, CFrz, CFrz);
    step("ms_frz4", 4'b0000, CFrz, CFrz);
    mem_stall = 1'b0;
    step("ms_b2", 4'b0000, CRun, CBub);
    step("ms_b3", 4'b0000, CRun, CBub);
    step("ms_done", 4'b0000, CRun, CRun);

    // halt_ex together with redirect: flush wins
    halt_ex = 1'b1; redirect = 1'b1;
    step("hr_flush", 4'b0000, CRedir, CRedir);
    halt_ex = 1'b0; redirect = 1'b0;
    step("hr_run", 4'b0000, CRun, CRun);

    // HALT parks the pipeline until reset
    halt_ex = 1'b1;
    step("h_enter", 4'b0000, CBub, CBub);
    halt_ex = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == 4) redirect = 1'b1;
      if (i == 5) redirect = 1'b0;
      if (i == 7) mem_stall = 1'b1;
      if (i == 8) mem_stall = 1'b0;
      if (i == 7) step("h_frz", 4'b0000, CHltFrz, CHltFrz);
      else        step("h_park", 4'b0000, CHlt, CHlt);
    end
    rst = 1'b1;
    step("h_async_rst", 4'b0000, CRun, CRun);
    rst = 1'b0;
    step("h_post_rst", 4'b0000, CRun, CRun);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 16-bit execute stage.
- Generates the forwardA/forwardB operand-select codes for the execute stage.
- Detects load-use hazards and inserts bubbles; squashes younger instructions on a taken branch/jump redirect.
- Freezes the whole pipeline while data memory is busy, and parks the pipeline after HALT.

Parameters:
- LOADUSE_STALL, default 1: bubble cycles inserted per load-use hazard. Legal range 1..3.
- REG_BITS, default 3: register-specifier width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- ifid_rs, ifid_rt  in  REG_BITS  source registers of the instruction in IF/ID
- ifid_useRs, ifid_useRt  in  1  the IF/ID instruction actually reads rs/rt
- idex_rs, idex_rt  in  REG_BITS  source registers of the instruction in EX
- idex_useRs, idex_useRt  in  1  the EX instruction reads rs/rt
- idex_rd  in  REG_BITS  destination register of the EX instruction
- idex_regWrite, idex_memRead  in  1  the EX instruction writes a register / is a load
- exmem_rd, exmem_regWrite, exmem_memRead  in  REG_BITS,1,1  EX/MEM destination info
- memwb_rd, memwb_regWrite  in  REG_BITS,1  MEM/WB destination info
- redirect  in  1  EX resolved a taken branch, jump or jumpReg (nextPC differs from sequential PC)
- halt_ex  in  1  HALT instruction is in EX
- mem_stall  in  1  data memory busy this cycle
- forwardA, forwardB  out  2  operand select: 00 register file, 01 MEM/WB writeback, 10 EX/MEM ALURes
- pc_write, ifid_write  out  1  PC / IF-ID register load enable
- idex_bubble  out  1  load a NOP into ID/EX at the next edge
- ifid_flush  out  1  load a NOP into IF/ID at the next edge
- pipe_freeze  out  1  hold every pipeline register
- halted  out  1  pipeline parked after HALT

Behaviour:
- Reset (async, rst=1):
  - FSM state is RUN and the stall counter is 0.
  - Outputs: forwardA=forwardB=00, pc_write=ifid_write=1, idex_bubble=ifid_flush=pipe_freeze=halted=0.
- Forwarding (combinational, evaluated every cycle, independent of state):
  - forwardA=10 when exmem_regWrite & ~exmem_memRead & idex_useRs & exmem_rd==idex_rs.
  - Otherwise forwardA=01 when memwb_regWrite & idex_useRs & memwb_rd==idex_rs.
  - Otherwise forwardA=00.
  - forwardB uses the same rules with rt/useRt.
  - EX/MEM has priority over MEM/WB.
  - R0 is an ordinary register; there is no zero-register exclusion.
  - Code 11 is never driven.
- FSM states: RUN, STALL, HALTED. Events are evaluated in priority order (first match wins):
  1. mem_stall=1:
     - pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0.
     - State and counter hold; redirect/halt_ex are ignored, since EX is held and re-presents them.
  2. redirect=1 (RUN or STALL):
     - ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
     - Next state RUN, counter cleared. Redirect cancels any pending load-use stall.
  3. halt_ex=1 (RUN or STALL): next state HALTED; this cycle pc_write=0, ifid_write=0, idex_bubble=1.
  4. RUN with load-use hazard:
     - Hazard condition: idex_memRead & idex_regWrite & ((ifid_useRs & idex_rd==ifid_rs) | (ifid_useRt & idex_rd==ifid_rt)).
     - pc_write=0, ifid_write=0, idex_bubble=1.
     - If LOADUSE_STALL>1: next state STALL with counter=LOADUSE_STALL-1. Otherwise stay in RUN.
  5. STALL:
     - Same outputs as the load-use case; counter decrements each non-frozen cycle.
     - When counter reaches 1, next state is RUN.
  6. RUN, no event: pc_write=1, ifid_write=1, all other control outputs 0.
- HALTED:
  - halted=1, pc_write=0, ifid_write=0, idex_bubble=1.
  - mem_stall still asserts pipe_freeze.
  - Exit only via rst.
- Latency:
  - All control outputs are combinational from inputs and state, and take effect at the next rising edge.
  - State updates on the rising edge.
- rst asserted mid-stall or mid-halt returns to RUN immediately.

Test Plan:
- idex_rs=3, useRs=1; exmem_rd=3, regWrite=1, memRead=0; memwb_rd=3, regWrite=1 -> forwardA=10. Then clear exmem_regWrite -> forwardA=01.
- Load writing R2 in EX, IF/ID reads R2 via rt, LOADUSE_STALL=1 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1, then RUN. With LOADUSE_STALL=3 -> exactly 3 bubble cycles.
- Load-use stall in progress (LOADUSE_STALL=3, second cycle) and redirect=1 -> ifid_flush=1, idex_bubble=1, pc_write=1; next cycle RUN with no bubble.
- mem_stall=1 for 4 cycles during a 3-cycle load-use stall -> pipe_freeze=1 throughout, counter held; after release the remaining bubble cycles complete, 3 in total.
- halt_ex=1 with redirect=0 -> next cycle halted=1 and pc_write=0, holding for 10+ cycles. Assert rst asynchronously -> halted=0 and pc_write=1 before the next clock edge.
- halt_ex=1 and redirect=1 in the same cycle -> flush wins, state RUN, halted stays 0.
